// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_we,
    input  logic [31:0] i_wd,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic        w_op_valid;
    logic        w_is_div;
    logic        w_b_zero;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_divisor;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_op_valid = (i_op >= OP_MULT) && (i_op <= OP_DIVU);
    assign w_is_div   = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_b_zero   = (r_b == 32'd0);

    // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Divisor forced non-zero so the dividers never see x/0; the result is discarded then.
    assign w_divisor = w_b_zero ? 32'd1 : r_b;
    assign w_uq      = r_a / w_divisor;
    assign w_ur      = r_a % w_divisor;

    // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000, remainder 0.
    assign w_a_abs  = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_b_abs  = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
    assign w_sq_mag = w_a_abs / w_b_abs;
    assign w_sr_mag = w_a_abs % w_b_abs;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV: begin
                w_res_lo = (r_a[31] ^ w_divisor[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
                w_res_hi = r_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
            end
            OP_DIVU: begin
                w_res_lo = w_uq;
                w_res_hi = w_ur;
            end
            default: begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_op_valid) begin
                        r_op    <= i_op;
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_cnt   <= (i_op <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else if (!i_start) begin
                        if (i_we[1]) r_hi <= i_wd;
                        if (i_we[0]) r_lo <= i_wd;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (!(w_is_div && w_b_zero)) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  we;
    logic [31:0] wd;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_we    (we),
        .i_wd    (wd),
        .o_busy  (busy),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [2:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b);
        longint sa, sb, q, r, ps;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        ua = {32'd0, m_a};
        ub = {32'd0, m_b};
        case (m_op)
            3'd1: begin ps = sa * sb; exp_hi = ps[63:32]; exp_lo = ps[31:0]; end
            3'd2: begin pu = ua * ub; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
            3'd3: if (m_b != 0) begin
                q = sa / sb; r = sa % sb;
                exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            3'd4: if (m_b != 0) begin
                exp_lo = m_a / m_b; exp_hi = m_a % m_b;
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input bit interfere, input string tag);
        int n;
        logic [31:0] pre_hi, pre_lo;
        n = (o <= 3'd2) ? 5 : 10;
        pre_hi = exp_hi;
        pre_lo = exp_lo;
        start = 1'b1; op = o; a = va; b = vb;
        step();
        start = 1'b0; op = 3'd0;
        for (int k = 0; k < n; k++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_hold_hi"}, hi, pre_hi);
            check({tag, "_hold_lo"}, lo, pre_lo);
            if (interfere && k == 1) begin
                start = 1'b1; op = 3'd3; a = $urandom; b = 32'd1;
                we = 2'b11; wd = $urandom;
            end
            step();
            start = 1'b0; op = 3'd0; we = 2'b00;
        end
        model(o, va, vb);
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic write_reg(input logic [1:0] w, input logic [31:0] d, input string tag);
        we = w; wd = d;
        step();
        we = 2'b00;
        if (w[1]) exp_hi = d;
        if (w[0]) exp_lo = d;
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int sel;
        n_cmp = 0; n_fail = 0;
        exp_hi = 0; exp_lo = 0;
        reset = 1'b1; start = 0; op = 0; a = 0; b = 0; we = 0; wd = 0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, "mult_neg");
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, "multu");
        check("multu_hi_const", hi, 32'h00000001);
        check("multu_lo_const", lo, 32'hFFFFFFFE);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
        check("div_lo_const", lo, 32'hFFFFFFFD);
        check("div_hi_const", hi, 32'hFFFFFFFF);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, "divu");
        check("divu_lo_const", lo, 32'h7FFFFFFC);
        check("divu_hi_const", hi, 32'h00000001);

        write_reg(2'b10, 32'h1234, "mthi");
        write_reg(2'b01, 32'h5678, "mtlo");
        run_op(3'd4, 32'hDEADBEEF, 32'd0, 1'b0, "divu_b0");
        check("divu_b0_hi_const", hi, 32'h1234);
        check("divu_b0_lo_const", lo, 32'h5678);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        check("div_ovf_lo_const", lo, 32'h80000000);
        check("div_ovf_hi_const", hi, 32'h0);

        run_op(3'd1, 32'h00012345, 32'hFFFF0003, 1'b1, "mult_interfere");

        for (int i = 5; i < 8; i++) begin
            start = 1'b1; op = 3'(i); a = $urandom; b = $urandom;
            step();
            start = 1'b0; op = 3'd0;
            check("reserved_busy", {31'd0, busy}, 32'd0);
            check("reserved_hi", hi, exp_hi);
            check("reserved_lo", lo, exp_lo);
        end

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 4);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            if (sel == 0) write_reg(2'($urandom_range(1, 2)), ra, "rnd_mt");
            else run_op(3'(sel), ra, rb, 1'b0, "rnd_op");
        end

        write_reg(2'b10, 32'hA5A5A5A5, "pre_rst_hi");
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0; op = 3'd0;
        step(); step(); step();
        #2 reset = 1'b1;
        #1;
        exp_hi = 0; exp_lo = 0;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        #2 reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("after_rst_busy", {31'd0, busy}, 32'd0);
            check("after_rst_hi", hi, 32'd0);
            check("after_rst_lo", lo, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
